// File: rtl/gmt_out_align_if.sv
// Track/LUT/muon-word bundle between the sector core, the PT LUT and gmt_out_align.
// master drives the track requests and LUT returns; slave (gmt_out_align) drives the muon words.
interface gmt_out_align_if;
  logic [2:0]       ptlut_addr_val;
  logic [2:0][7:0]  gmt_phi;
  logic [2:0][8:0]  gmt_eta;
  logic [2:0][3:0]  gmt_qlt;
  logic [2:0]       gmt_crg;
  logic [2:0]       ptlut_dv;
  logic [2:0][8:0]  ptlut_pt;
  logic [2:0][63:0] mu_word;
  logic [2:0]       mu_val;

  modport master (
    output ptlut_addr_val, gmt_phi, gmt_eta, gmt_qlt, gmt_crg, ptlut_dv, ptlut_pt,
    input  mu_word, mu_val
  );

  modport slave (
    input  ptlut_addr_val, gmt_phi, gmt_eta, gmt_qlt, gmt_crg, ptlut_dv, ptlut_pt,
    output mu_word, mu_val
  );
endinterface

// File: rtl/gmt_out_align.sv
// Delays best-track GMT fields by the PT LUT latency, merges the returned pT and stamps BX/sector.
// Optional saturating missing-LUT counter enabled by defining GMT_OUT_MISS_CNT_EN.
module gmt_out_align #(
  parameter int DEPTH  = 16,
  parameter int BX_MAX = 3563
) (
  input  logic           clk,
  input  logic           rst,
  gmt_out_align_if.slave bus,
  input  logic           bc0,
  input  logic [3:0]     lut_lat,
  input  logic [2:0]     sector,
  input  logic           endcap,
  output logic [11:0]    bx_cnt,
  output logic           bc0_err,
  output logic [2:0]     lut_miss,
  output logic [15:0]    miss_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0][7:0] phi;
    logic [2:0][8:0] eta;
    logic [2:0][3:0] qlt;
    logic [2:0]      crg;
  } trk_t;

  trk_t                  trk_mem [DEPTH];
  trk_t                  wr_trk;
  trk_t                  rd_trk;
  logic [DEPTH-1:0][2:0] val_reg;
  logic [AW-1:0]         wptr_reg;
  logic [AW-1:0]         rd_idx;
  logic [3:0]            lat_eff;
  logic [3:0]            lat_prev_reg;
  logic                  lat_init_reg;
  logic                  lat_change;
  logic [2:0]            rd_val;
  logic [11:0]           bx_next;
  logic [63:0]           word_next [3];
  logic [2:0]            miss_next;

  always_comb begin
    wr_trk     = '0;
    wr_trk.phi = bus.gmt_phi;
    wr_trk.eta = bus.gmt_eta;
    wr_trk.qlt = bus.gmt_qlt;
    wr_trk.crg = bus.gmt_crg;
  end

  assign lat_eff    = (lut_lat == 4'd0) ? 4'd1 : lut_lat;
  // The first cycle after reset has no previous latency to compare against.
  assign lat_change = lat_init_reg && (lat_eff != lat_prev_reg);
  assign rd_idx     = wptr_reg - AW'(lat_eff);
  assign rd_trk     = trk_mem[rd_idx];
  assign rd_val     = lat_change ? 3'b000 : val_reg[rd_idx];
  assign bx_next    = (bc0 || bx_cnt == 12'(BX_MAX)) ? 12'd0 : bx_cnt + 12'd1;

  // Payload RAM carries no reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    trk_mem[wptr_reg] <= wr_trk;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg     <= '0;
      val_reg      <= '0;
      lat_prev_reg <= 4'd1;
      lat_init_reg <= 1'b0;
    end else begin
      wptr_reg     <= wptr_reg + 1'b1;
      lat_prev_reg <= lat_eff;
      lat_init_reg <= 1'b1;
      if (lat_change) begin
        val_reg <= '0;
      end else begin
        val_reg[wptr_reg] <= bus.ptlut_addr_val;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_trk
      logic [8:0] pt_sel;
      assign pt_sel        = bus.ptlut_dv[gi] ? bus.ptlut_pt[gi] : 9'd0;
      assign miss_next[gi] = rd_val[gi] & ~bus.ptlut_dv[gi];
      assign word_next[gi] = rd_val[gi] ?
        {15'd0, endcap, sector, bx_next, 1'b1, (rd_trk.qlt[gi] != 4'd0), rd_trk.crg[gi],
         rd_trk.qlt[gi], rd_trk.phi[gi], rd_trk.eta[gi], pt_sel} : 64'd0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mu_word <= '0;
      bus.mu_val  <= '0;
      lut_miss    <= '0;
      bx_cnt      <= '0;
      bc0_err     <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        bus.mu_word[i] <= word_next[i];
      end
      bus.mu_val <= rd_val;
      lut_miss   <= miss_next;
      bx_cnt     <= bx_next;
      if (bc0 && bx_cnt != 12'(BX_MAX)) begin
        bc0_err <= 1'b1;
      end
    end
  end

`ifdef GMT_OUT_MISS_CNT_EN
  logic [1:0]  miss_pop;
  logic [16:0] miss_sum;

  // Counts the same misses that appear on lut_miss in the same cycle.
  assign miss_pop = 2'(miss_next[0]) + 2'(miss_next[1]) + 2'(miss_next[2]);
  assign miss_sum = {1'b0, miss_cnt} + 17'(miss_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      miss_cnt <= '0;
    end else begin
      miss_cnt <= miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
    end
  end
`else
  assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_gmt_out_align.sv
// Scoreboard bench for gmt_out_align: table vectors, latency change, reset and BX/BC0 sequences.
module tb_gmt_out_align;
  localparam int BXM = 3563;

  typedef struct packed {
    logic [3:0]      lat;
    logic [2:0]      av;
    logic [2:0][7:0] phi;
    logic [2:0][8:0] eta;
    logic [2:0][3:0] qlt;
    logic [2:0]      crg;
    logic [2:0]      dv;
    logic [2:0][8:0] pt;
    logic [2:0]      exp_val;
    logic [2:0]      exp_miss;
  } vec_t;

  typedef struct {
    int   due;
    vec_t v;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bc0 = 1'b0;
  logic [3:0]  lut_lat = 4'd3;
  logic [2:0]  sector = 3'd5;
  logic        endcap = 1'b1;
  logic [11:0] bx_cnt;
  logic        bc0_err;
  logic [2:0]  lut_miss;
  logic [15:0] miss_cnt;

  gmt_out_align_if bus ();

  gmt_out_align dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .bc0      (bc0),
    .lut_lat  (lut_lat),
    .sector   (sector),
    .endcap   (endcap),
    .bx_cnt   (bx_cnt),
    .bc0_err  (bc0_err),
    .lut_miss (lut_miss),
    .miss_cnt (miss_cnt)
  );

  always #5 clk = ~clk;

  int              n_cmp = 0;
  int              n_err = 0;
  int              cyc = 0;
  int              bx_exp = 0;
  int              miss_total = 0;
  logic            err_exp = 1'b0;
  logic            lat_chg = 1'b0;
  sb_t             sb_q[$];
  logic [2:0]      dv_sched [64];
  logic [2:0][8:0] pt_sched [64];
  vec_t            tab [8];

  function automatic int eff(input logic [3:0] l);
    return (l == 4'd0) ? 1 : int'(l);
  endfunction

  function automatic logic [63:0] mk_word(input vec_t v, input int i, input logic [11:0] bx);
    logic [8:0] pt;
    pt = v.exp_miss[i] ? 9'd0 : v.pt[i];
    if (!v.exp_val[i]) return 64'd0;
    return {15'd0, endcap, sector, bx, 1'b1, (v.qlt[i] != 4'd0), v.crg[i],
            v.qlt[i], v.phi[i], v.eta[i], pt};
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    r          = '0;
    r.av       = 3'($urandom_range(1, 7));
    r.phi      = 24'($urandom);
    r.eta      = 27'($urandom);
    r.qlt      = 12'($urandom);
    r.crg      = 3'($urandom);
    r.dv       = r.av;
    r.pt       = 27'($urandom);
    r.exp_val  = r.av;
    r.exp_miss = 3'b000;
    return r;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic b;
    b = bc0;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      bx_exp = 0;
    end else begin
      if (b && bx_exp != BXM) err_exp = 1'b1;
      bx_exp = (b || bx_exp == BXM) ? 0 : bx_exp + 1;
    end
  endtask

  task automatic check();
    sb_t e;
    logic [63:0] miss_cnt_exp;
    cmp("bx_cnt", 64'(bx_cnt), 64'(bx_exp));
    cmp("bc0_err", 64'(bc0_err), 64'(err_exp));
    if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
      e = sb_q.pop_front();
      cmp("mu_val", 64'(bus.mu_val), 64'(e.v.exp_val));
      cmp("lut_miss", 64'(lut_miss), 64'(e.v.exp_miss));
      for (int i = 0; i < 3; i++) begin
        cmp($sformatf("mu_word%0d", i), bus.mu_word[i], mk_word(e.v, i, 12'(bx_exp)));
      end
      miss_total += $countones(e.v.exp_miss);
`ifdef GMT_OUT_MISS_CNT_EN
      miss_cnt_exp = 64'(miss_total);
`else
      miss_cnt_exp = 64'd0;
`endif
      cmp("miss_cnt", 64'(miss_cnt), miss_cnt_exp);
      $display("txn cycle=%0d val=%b miss=%b w0=%h w1=%h w2=%h", cyc, bus.mu_val, lut_miss,
               bus.mu_word[0], bus.mu_word[1], bus.mu_word[2]);
    end else begin
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
        cmp("sb_overdue", 64'(sb_q[0].due), 64'(cyc));
        void'(sb_q.pop_front());
      end
      cmp("idle_mu_val", 64'(bus.mu_val), 64'd0);
      cmp("idle_lut_miss", 64'(lut_miss), 64'd0);
    end
  endtask

  task automatic cycle(input vec_t v, input logic req);
    int  slot;
    int  lat;
    sb_t e;
    lat  = eff(lut_lat);
    slot = cyc % 64;
    bus.ptlut_addr_val = req ? v.av : 3'b000;
    bus.gmt_phi        = v.phi;
    bus.gmt_eta        = v.eta;
    bus.gmt_qlt        = v.qlt;
    bus.gmt_crg        = v.crg;
    bus.ptlut_dv       = dv_sched[slot];
    bus.ptlut_pt       = pt_sched[slot];
    dv_sched[slot]     = '0;
    pt_sched[slot]     = '0;
    // A request driven in the latency-change cycle is discarded by the design.
    if (req && !lat_chg) begin
      e.due = cyc + lat + 1;
      e.v   = v;
      sb_q.push_back(e);
      dv_sched[(cyc + lat) % 64] = v.dv;
      pt_sched[(cyc + lat) % 64] = v.pt;
    end
    lat_chg = 1'b0;
    tick();
    check();
  endtask

  task automatic set_lat(input logic [3:0] l);
    lut_lat = l;
    sb_q.delete();
    lat_chg = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 32 && sb_q.size() > 0; k++) cycle('0, 1'b0);
    if (sb_q.size() > 0) begin
      cmp("drain_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    cmp("rst_mu_val", 64'(bus.mu_val), 64'd0);
    for (int i = 0; i < 3; i++) cmp("rst_mu_word", bus.mu_word[i], 64'd0);
    cmp("rst_bx_cnt", 64'(bx_cnt), 64'd0);
    cmp("rst_bc0_err", 64'(bc0_err), 64'd0);
    cmp("rst_lut_miss", 64'(lut_miss), 64'd0);
    cmp("rst_miss_cnt", 64'(miss_cnt), 64'd0);
    tick();
    tick();
    cmp("rst_hold_mu_val", 64'(bus.mu_val), 64'd0);
    rst        = 1'b0;
    cyc        = 0;
    bx_exp     = 0;
    err_exp    = 1'b0;
    miss_total = 0;
    lat_chg    = 1'b0;
    sb_q.delete();
    for (int i = 0; i < 64; i++) begin
      dv_sched[i] = '0;
      pt_sched[i] = '0;
    end
    cmp("rel_bx_cnt", 64'(bx_cnt), 64'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int   c_chg;
    int   first_val;
    vec_t r;

    // {lat, av, phi, eta, qlt, crg, dv, pt, exp_val, exp_miss}; index 2 is written first.
    tab[0] = '{4'd3, 3'b001, {8'h00, 8'h00, 8'h5A}, {9'h000, 9'h000, 9'h123}, {4'h0, 4'h0, 4'hC},
               3'b001, 3'b001, {9'h000, 9'h000, 9'h0A5}, 3'b001, 3'b000};
    tab[1] = '{4'd3, 3'b111, {8'h01, 8'h80, 8'hFF}, {9'h1FF, 9'h000, 9'h0AA}, {4'h0, 4'hF, 4'h1},
               3'b101, 3'b111, {9'h1FF, 9'h100, 9'h001}, 3'b111, 3'b000};
    tab[2] = '{4'd3, 3'b000, {8'h11, 8'h22, 8'h33}, {9'h044, 9'h055, 9'h066}, {4'h1, 4'h2, 4'h3},
               3'b111, 3'b011, {9'h077, 9'h088, 9'h099}, 3'b000, 3'b000};
    tab[3] = '{4'd3, 3'b010, {8'h00, 8'hC3, 8'h00}, {9'h000, 9'h13C, 9'h000}, {4'h0, 4'h9, 4'h0},
               3'b000, 3'b000, {9'h000, 9'h0FF, 9'h000}, 3'b010, 3'b010};
    tab[4] = '{4'd2, 3'b110, {8'h33, 8'h22, 8'h11}, {9'h103, 9'h102, 9'h101}, {4'h7, 4'h6, 4'h0},
               3'b010, 3'b010, {9'h1AB, 9'h0CD, 9'h0EF}, 3'b110, 3'b100};
    tab[5] = '{4'd2, 3'b011, {8'h00, 8'h7E, 8'h81}, {9'h000, 9'h0F0, 9'h10F}, {4'h0, 4'h8, 4'h4},
               3'b011, 3'b011, {9'h000, 9'h155, 9'h0AA}, 3'b011, 3'b000};
    tab[6] = '{4'd0, 3'b100, {8'h9C, 8'h00, 8'h00}, {9'h1C9, 9'h000, 9'h000}, {4'hE, 4'h0, 4'h0},
               3'b100, 3'b100, {9'h123, 9'h000, 9'h000}, 3'b100, 3'b000};
    tab[7] = '{4'd0, 3'b111, {8'h10, 8'h20, 8'h30}, {9'h040, 9'h050, 9'h060}, {4'h5, 4'h0, 4'hB},
               3'b011, 3'b101, {9'h070, 9'h080, 9'h090}, 3'b111, 3'b010};

    bus.ptlut_addr_val = '0;
    bus.gmt_phi        = '0;
    bus.gmt_eta        = '0;
    bus.gmt_qlt        = '0;
    bus.gmt_crg        = '0;
    bus.ptlut_dv       = '0;
    bus.ptlut_pt       = '0;
    #2;
    do_reset();

    // Table vectors, pipelined one per cycle; a latency change inserts an idle change cycle.
    for (int n = 0; n < 8; n++) begin
      if (tab[n].lat != lut_lat) begin
        drain();
        set_lat(tab[n].lat);
        cycle('0, 1'b0);
      end
      cycle(tab[n], 1'b1);
    end
    drain();

    // Latency 3 -> 7 with a request every clock.
    set_lat(4'd3);
    cycle('0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(rnd_vec(), 1'b1);
    set_lat(4'd7);
    c_chg     = cyc;
    first_val = -1;
    for (int i = 0; i < 14; i++) begin
      cycle(rnd_vec(), 1'b1);
      if (first_val < 0 && bus.mu_val != 3'b000) first_val = cyc;
    end
    cmp("lat_change_gap", 64'(first_val - c_chg), 64'd9);
    drain();

    // Reset with three requests in flight.
    set_lat(4'd3);
    cycle('0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(rnd_vec(), 1'b1);
    do_reset();
    for (int i = 0; i < 12; i++) cycle('0, 1'b0);

    // BX counter wrap without bc0, bc0 on the wrap, then a misplaced bc0.
    while (cyc < BXM) cycle('0, 1'b0);
    cmp("bx_pre_wrap", 64'(bx_cnt), 64'd3563);
    cycle('0, 1'b0);
    cmp("bx_wrap", 64'(bx_cnt), 64'd0);
    cmp("bx_wrap_err", 64'(bc0_err), 64'd0);
    for (int k = 0; k < 4000 && bx_exp != BXM; k++) cycle('0, 1'b0);
    bc0 = 1'b1;
    cycle('0, 1'b0);
    bc0 = 1'b0;
    cmp("bc0_at_wrap_bx", 64'(bx_cnt), 64'd0);
    cmp("bc0_at_wrap_err", 64'(bc0_err), 64'd0);
    for (int k = 0; k < 200 && bx_exp != 100; k++) cycle('0, 1'b0);
    cmp("bx_at_100", 64'(bx_cnt), 64'd100);
    bc0 = 1'b1;
    cycle('0, 1'b0);
    bc0 = 1'b0;
    cmp("bc0_early_bx", 64'(bx_cnt), 64'd0);
    cmp("bc0_early_err", 64'(bc0_err), 64'd1);
    for (int i = 0; i < 5; i++) cycle('0, 1'b0);
    cmp("bc0_err_sticky", 64'(bc0_err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
